// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Packs symbolic instruction requests (operation select plus operand fields)
// into 32-bit MIPS-I instruction words and writes them to sequential
// instruction-SRAM word addresses. Only the instruction subset recognised by
// the core's decoder can be produced; any other operation select is flagged
// and dropped.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, start_addr     one-cycle pulse: flush, load address, enter RUN
//   req_valid/req_ready   request handshake
//   req_op                operation select (1..44 valid)
//   req_rs/rt/rd/sa       register and shift-amount fields
//   req_imm               imm16 in [15:0], or 26-bit target for J/JAL
//   wr_valid/wr_ready     SRAM write handshake
//   wr_addr, wr_data      write word address and encoded instruction
//   err_invalid           sticky flag: an invalid req_op was accepted
//   full                  last address consumed, no more requests accepted
//   word_cnt              SRAM writes completed since start
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            req_op,
    input  logic [4:0]            req_rs,
    input  logic [4:0]            req_rt,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_sa,
    input  logic [25:0]           req_imm,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  err_invalid,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_cnt;
    logic [31:0]           r_fifo_word [2];
    logic [ADDR_WIDTH-1:0] r_fifo_addr [2];
    logic                  r_err;
    logic [ADDR_WIDTH:0]   r_word_cnt;

    logic [32:0]           w_enc;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] funct);
        return {6'h00, rs, rt, rd, sa, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // Returns {valid, word}. Fields an instruction does not use are forced to
    // zero so the word is canonical regardless of what the loader sent.
    function automatic logic [32:0] encode(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sa, input logic [25:0] imm);
        logic [32:0] r;
        logic [15:0] i16;
        i16 = imm[15:0];
        r   = '0;
        case (op)
            6'd1:  r = {1'b1, rtype(5'd0, rt, rd, sa, 6'h00)};     // SLL
            6'd2:  r = {1'b1, rtype(5'd0, rt, rd, sa, 6'h02)};     // SRL
            6'd3:  r = {1'b1, rtype(5'd0, rt, rd, sa, 6'h03)};     // SRA
            6'd4:  r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h04)};     // SLLV
            6'd5:  r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h06)};     // SRLV
            6'd6:  r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h07)};     // SRAV
            6'd7:  r = {1'b1, rtype(rs, 5'd0, 5'd0, 5'd0, 6'h08)}; // JR
            6'd8:  r = {1'b1, rtype(rs, 5'd0, rd, 5'd0, 6'h09)};   // JALR
            6'd9:  r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h20)};     // ADD
            6'd10: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h21)};     // ADDU
            6'd11: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h22)};     // SUB
            6'd12: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h23)};     // SUBU
            6'd13: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h24)};     // AND
            6'd14: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h25)};     // OR
            6'd15: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h26)};     // XOR
            6'd16: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h27)};     // NOR
            6'd17: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h2A)};     // SLT
            6'd18: r = {1'b1, rtype(rs, rt, rd, 5'd0, 6'h2B)};     // SLTU
            // REGIMM: the rt field selects the branch condition
            6'd19: r = {1'b1, itype(6'h01, rs, 5'd0, i16)};        // BLTZ
            6'd20: r = {1'b1, itype(6'h01, rs, 5'd1, i16)};        // BGEZ
            6'd21: r = {1'b1, itype(6'h01, rs, 5'd16, i16)};       // BLTZAL
            6'd22: r = {1'b1, itype(6'h01, rs, 5'd17, i16)};       // BGEZAL
            6'd23: r = {1'b1, 6'h02, imm};                         // J
            6'd24: r = {1'b1, 6'h03, imm};                         // JAL
            6'd25: r = {1'b1, itype(6'h04, rs, rt, i16)};          // BEQ
            6'd26: r = {1'b1, itype(6'h05, rs, rt, i16)};          // BNE
            6'd27: r = {1'b1, itype(6'h06, rs, 5'd0, i16)};        // BLEZ
            6'd28: r = {1'b1, itype(6'h07, rs, 5'd0, i16)};        // BGTZ
            6'd29: r = {1'b1, itype(6'h08, rs, rt, i16)};          // ADDI
            6'd30: r = {1'b1, itype(6'h09, rs, rt, i16)};          // ADDIU
            6'd31: r = {1'b1, itype(6'h0A, rs, rt, i16)};          // SLTI
            6'd32: r = {1'b1, itype(6'h0B, rs, rt, i16)};          // SLTIU
            6'd33: r = {1'b1, itype(6'h0C, rs, rt, i16)};          // ANDI
            6'd34: r = {1'b1, itype(6'h0D, rs, rt, i16)};          // ORI
            6'd35: r = {1'b1, itype(6'h0E, rs, rt, i16)};          // XORI
            6'd36: r = {1'b1, itype(6'h0F, 5'd0, rt, i16)};        // LUI
            6'd37: r = {1'b1, itype(6'h20, rs, rt, i16)};          // LB
            6'd38: r = {1'b1, itype(6'h21, rs, rt, i16)};          // LH
            6'd39: r = {1'b1, itype(6'h23, rs, rt, i16)};          // LW
            6'd40: r = {1'b1, itype(6'h24, rs, rt, i16)};          // LBU
            6'd41: r = {1'b1, itype(6'h25, rs, rt, i16)};          // LHU
            6'd42: r = {1'b1, itype(6'h28, rs, rt, i16)};          // SB
            6'd43: r = {1'b1, itype(6'h29, rs, rt, i16)};          // SH
            6'd44: r = {1'b1, itype(6'h2B, rs, rt, i16)};          // SW
            default: r = '0;
        endcase
        return r;
    endfunction

    assign w_enc    = encode(req_op, req_rs, req_rt, req_rd, req_sa, req_imm);
    // A request coinciding with start belongs to the old program and is dropped.
    assign w_accept = req_valid && req_ready && !start;
    assign w_push   = w_accept && w_enc[32];
    assign w_pop    = wr_valid && wr_ready;
    assign w_last   = (r_addr == {ADDR_WIDTH{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = S_RUN;
        end else if (r_state == S_RUN && w_push && w_last) begin
            w_next_state = S_FULL;
        end
    end

    // State-derived outputs: req_ready depends only on registered state so
    // there is no combinational path from wr_ready.
    always_comb begin
        req_ready = (r_state == S_RUN) && (r_cnt < 2'd2);
        full      = (r_state == S_FULL);
    end

    // Address counter, 2-entry FIFO (slot 0 is always the head) and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_word[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
        end else if (start) begin
            r_addr     <= start_addr;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            if (w_accept && !w_enc[32]) begin
                r_err <= 1'b1;
            end
            if (w_push) begin
                // Wrapped value is never used: the FSM stops in FULL.
                r_addr <= w_last ? '0 : r_addr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + (ADDR_WIDTH+1)'(1);
            end
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_fifo_word[0] <= w_enc[31:0];
                        r_fifo_addr[0] <= r_addr;
                    end else begin
                        r_fifo_word[1] <= w_enc[31:0];
                        r_fifo_addr[1] <= r_addr;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_fifo_word[0] <= r_fifo_word[1];
                    r_fifo_addr[0] <= r_fifo_addr[1];
                    r_cnt          <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: new word lands behind
                    // whatever remains after the pop.
                    if (r_cnt == 2'd1) begin
                        r_fifo_word[0] <= w_enc[31:0];
                        r_fifo_addr[0] <= r_addr;
                    end else begin
                        r_fifo_word[0] <= r_fifo_word[1];
                        r_fifo_addr[0] <= r_fifo_addr[1];
                        r_fifo_word[1] <= w_enc[31:0];
                        r_fifo_addr[1] <= r_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_valid    = (r_cnt != 2'd0);
    assign wr_addr     = r_fifo_addr[0];
    assign wr_data     = r_fifo_word[0];
    assign err_invalid = r_err;
    assign word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0, req_sa = '0;
    logic [25:0] req_imm = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err_invalid, full;
    logic [10:0] word_cnt;

    logic        start4 = 1'b0;
    logic [3:0]  start_addr4 = '0;
    logic        req_valid4 = 1'b0;
    logic        req_ready4;
    logic        wr_valid4;
    logic        wr_ready4 = 1'b0;
    logic [3:0]  wr_addr4;
    logic [31:0] wr_data4;
    logic        err_invalid4, full4;
    logic [4:0]  word_cnt4;

    inst_encoder #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa),
        .req_imm(req_imm), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .err_invalid(err_invalid),
        .full(full), .word_cnt(word_cnt)
    );

    inst_encoder #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .start_addr(start_addr4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_sa(req_sa),
        .req_imm(req_imm), .wr_valid(wr_valid4), .wr_ready(wr_ready4),
        .wr_addr(wr_addr4), .wr_data(wr_data4), .err_invalid(err_invalid4),
        .full(full4), .word_cnt(word_cnt4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: program queue of {addr, word} awaiting write
    logic [41:0] m_q [$];
    logic [41:0] got [$];
    int          m_state;   // 0 idle, 1 run, 2 full
    logic [9:0]  m_addr;
    logic        m_err;
    int          m_wcnt;
    logic        last_acc;

    localparam logic [5:0] RFUN [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                         6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
                                         6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    localparam logic [4:0] RIRT [4]  = '{5'd0, 5'd1, 5'd16, 5'd17};
    localparam logic [5:0] MEMOP [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    // Returns {valid, word} from the instruction-class rules
    function automatic logic [32:0] ref_enc(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [4:0] sa,
                                            input logic [25:0] imm);
        logic [31:0] w;
        w = '0;
        if (op < 1 || op > 44) return '0;
        if (op <= 18) begin
            w[25:21] = (op <= 3) ? 5'd0 : rs;
            w[20:16] = (op == 7 || op == 8) ? 5'd0 : rt;
            w[15:11] = (op == 7) ? 5'd0 : rd;
            w[10:6]  = (op <= 3) ? sa : 5'd0;
            w[5:0]   = RFUN[op-1];
        end else if (op <= 22) begin
            w = {6'd1, rs, RIRT[op-19], imm[15:0]};
        end else if (op <= 24) begin
            w = {6'(op - 21), imm};
        end else if (op <= 36) begin
            w = {6'(op - 21), (op == 36) ? 5'd0 : rs,
                 (op == 27 || op == 28) ? 5'd0 : rt, imm[15:0]};
        end else begin
            w = {MEMOP[op-37], rs, rt, imm[15:0]};
        end
        return {1'b1, w};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_q.delete();
        m_state = 0;
        m_addr  = '0;
        m_err   = 1'b0;
        m_wcnt  = 0;
    endtask

    // Compare outputs with the model, predict the coming edge, advance a cycle
    task automatic cycle();
        logic        exp_rdy;
        logic        pop;
        logic [32:0] e;
        exp_rdy = (m_state == 1) && (m_q.size() < 2);
        chk("req_ready", req_ready, exp_rdy);
        chk("wr_valid", wr_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("wr_addr", wr_addr, m_q[0][41:32]);
            chk("wr_data", wr_data, m_q[0][31:0]);
        end
        chk("err_invalid", err_invalid, m_err);
        chk("full", full, m_state == 2);
        chk("word_cnt", word_cnt, m_wcnt);
        pop      = (m_q.size() != 0) && wr_ready;
        last_acc = req_valid && exp_rdy && !start;
        if (start) begin
            m_q.delete();
            m_addr  = start_addr;
            m_err   = 1'b0;
            m_wcnt  = 0;
            m_state = 1;
        end else begin
            if (pop) begin
                got.push_back({wr_addr, wr_data});
                void'(m_q.pop_front());
                m_wcnt++;
            end
            if (last_acc) begin
                e = ref_enc(int'(req_op), req_rs, req_rt, req_rd, req_sa, req_imm);
                if (e[32]) begin
                    m_q.push_back({m_addr, e[31:0]});
                    if (m_addr == 10'h3FF) begin
                        m_state = 2;
                        m_addr  = '0;
                    end else begin
                        m_addr = m_addr + 10'd1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_start(input logic [9:0] a);
        start      = 1'b1;
        start_addr = a;
        cycle();
        start      = 1'b0;
    endtask

    task automatic set_req(input int op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sa, input logic [25:0] imm);
        req_op = 6'(op); req_rs = rs; req_rt = rt; req_rd = rd; req_sa = sa; req_imm = imm;
        req_valid = 1'b1;
    endtask

    // Leaves req_valid high so consecutive sends are back-to-back
    task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [25:0] imm);
        logic acc;
        set_req(op, rs, rt, rd, sa, imm);
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            cycle();
            acc = last_acc;
        end
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL send_timeout op=%0d observed=not_accepted expected=accepted", op);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_err"}, err_invalid, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
        chk({tag, "_full4"}, full4, 0);
    endtask

    logic [31:0] exp5 [5] = '{32'h00094080, 32'h03E00008, 32'h0C100000, 32'h04910010, 32'h8FBF0014};

    initial begin
        int acc4;
        int pop4;
        logic [3:0] a4 [$];

        // Reset state
        #1;
        check_reset_outputs("reset");
        reset_model();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Single ADDIU, one-cycle latency
        wr_ready = 1'b1;
        do_start(10'h010);
        send(30, 5'd29, 5'd29, 5'd0, 5'd0, 26'h000FFF8);
        req_valid = 1'b0;
        chk("addiu_valid", wr_valid, 1);
        chk("addiu_addr", wr_addr, 10'h010);
        chk("addiu_data", wr_data, 32'h27BDFFF8);
        idle(2);

        // Back-to-back program
        do_start(10'h020);
        got.delete();
        send(1,  5'd7,  5'd9,  5'd8, 5'd2, 26'h0);
        send(7,  5'd31, 5'd5,  5'd0, 5'd0, 26'h0);
        send(24, 5'd0,  5'd0,  5'd0, 5'd0, 26'h0100000);
        send(22, 5'd4,  5'd0,  5'd0, 5'd0, 26'h0000010);
        send(39, 5'd29, 5'd31, 5'd0, 5'd0, 26'h0000014);
        idle(4);
        chk("b2b_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            chk("b2b_data", got[i][31:0], exp5[i]);
            chk("b2b_addr", got[i][41:32], 10'h020 + 10'(i));
        end
        chk("b2b_word_cnt", word_cnt, 5);

        // Backpressure: two buffered, third held until drain
        wr_ready = 1'b0;
        got.delete();
        send(14, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
        send(15, 5'd4, 5'd5, 5'd6, 5'd0, 26'h0);
        set_req(16, 5'd7, 5'd8, 5'd9, 5'd0, 26'h0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_third_held", last_acc, 0);
        end
        chk("bp_ready_low", req_ready, 0);
        wr_ready = 1'b1;
        send(16, 5'd7, 5'd8, 5'd9, 5'd0, 26'h0);
        idle(4);
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_w0", got[0][31:0], 32'h00221825);
            chk("bp_w1", got[1][31:0], 32'h00853026);
            chk("bp_w2", got[2][31:0], 32'h00E84827);
        end

        // Invalid ops
        do_start(10'h055);
        got.delete();
        send(0, 5'd1, 5'd2, 5'd3, 5'd4, 26'h1234);
        req_valid = 1'b0;
        chk("inv_err_set", err_invalid, 1);
        send(50, 5'd1, 5'd2, 5'd3, 5'd4, 26'h1234);
        send(34, 5'd3, 5'd4, 5'd0, 5'd0, 26'h3FFABCD);
        idle(3);
        chk("inv_writes", got.size(), 1);
        if (got.size() == 1) begin
            chk("inv_addr", got[0][41:32], 10'h055);
            chk("inv_data", got[0][31:0], 32'h3464ABCD);
        end
        do_start(10'h0);
        chk("inv_err_clear", err_invalid, 0);

        // Narrow instance: last address then FULL
        start4 = 1'b1; start_addr4 = 4'd14;
        cycle();
        start4 = 1'b0;
        wr_ready4 = 1'b1;
        req_valid4 = 1'b1;
        req_op = 6'd34;
        acc4 = 0; pop4 = 0;
        for (int k = 0; k < 6; k++) begin
            if (req_valid4 && req_ready4) acc4++;
            if (wr_valid4 && wr_ready4) begin
                pop4++;
                a4.push_back(wr_addr4);
            end
            cycle();
        end
        req_valid4 = 1'b0;
        chk("aw4_accepts", acc4, 2);
        chk("aw4_pops", pop4, 2);
        if (a4.size() == 2) begin
            chk("aw4_addr0", a4[0], 14);
            chk("aw4_addr1", a4[1], 15);
        end
        chk("aw4_full", full4, 1);
        chk("aw4_ready", req_ready4, 0);
        chk("aw4_word_cnt", word_cnt4, 2);
        start4 = 1'b1; start_addr4 = 4'd0;
        cycle();
        start4 = 1'b0;
        chk("aw4_full_clear", full4, 0);
        chk("aw4_ready_back", req_ready4, 1);

        // Start flushes buffered words
        do_start(10'h100);
        wr_ready = 1'b0;
        send(10, 5'd1, 5'd1, 5'd1, 5'd0, 26'h0);
        send(11, 5'd2, 5'd2, 5'd2, 5'd0, 26'h0);
        req_valid = 1'b0;
        do_start(10'h000);
        chk("flush_wr_valid", wr_valid, 0);
        chk("flush_word_cnt", word_cnt, 0);
        got.delete();
        wr_ready = 1'b1;
        send(9, 5'd3, 5'd4, 5'd5, 5'd0, 26'h0);
        idle(3);
        chk("flush_next_count", got.size(), 1);
        if (got.size() == 1) chk("flush_next_addr", got[0][41:32], 0);

        // Asynchronous reset mid-stream
        do_start(10'h200);
        wr_ready = 1'b0;
        send(36, 5'd9, 5'd10, 5'd0, 5'd0, 26'h0BEEF);
        send(44, 5'd9, 5'd10, 5'd0, 5'd0, 26'h00004);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Randomised traffic, including runs into the top address
        do_start(10'd1000);
        for (int k = 0; k < 600; k++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0)
                req_op = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(45, 63));
            else
                req_op = 6'($urandom_range(1, 44));
            req_rs  = 5'($urandom);
            req_rt  = 5'($urandom);
            req_rd  = 5'($urandom);
            req_sa  = 5'($urandom);
            req_imm = 26'($urandom);
            wr_ready = ($urandom_range(0, 2) != 0);
            start = ($urandom_range(0, 79) == 0);
            start_addr = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(1015, 1023)) : 10'($urandom);
            cycle();
        end
        start = 1'b0;
        wr_ready = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and SRAM program writer: the inverse of the core's instruction decoder. Accepts symbolic instruction requests (operation select plus operand fields) from the self-test/debug loader, packs them into 32-bit MIPS-I instruction words, and writes them to sequential instruction-SRAM addresses through a valid/ready write port. It covers exactly the instruction subset the decoder recognises, so any word it emits decodes to the requested operation.

## Interface
- ADDR_WIDTH, 10, instruction-SRAM word-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  single-cycle pulse: load start_addr, clear counters/errors, enter RUN
- start_addr  in  ADDR_WIDTH  first write address
- req_valid / req_ready  in / out  1  request handshake; transfer when both high
- req_op  in  6  operation select (codes below)
- req_rs, req_rt, req_rd, req_sa  in  5 each  register/shift fields
- req_imm  in  26  imm16 in [15:0] for I-type/branch/load/store; full 26-bit target for J/JAL
- wr_valid / wr_ready  out / in  1  SRAM write handshake
- wr_addr  out  ADDR_WIDTH  write word address
- wr_data  out  32  encoded instruction
- err_invalid  out  1  sticky: an invalid req_op was accepted
- full  out  1  last address consumed; no further requests accepted
- word_cnt  out  ADDR_WIDTH+1  completed SRAM writes since start

## Operation
- req_op codes 1–44, in order: SLL SRL SRA SLLV SRLV SRAV JR JALR ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU BLTZ BGEZ BLTZAL BGEZAL J JAL BEQ BNE BLEZ BGTZ ADDI ADDIU SLTI SLTIU ANDI ORI XORI LUI LB LH LW LBU LHU SB SH SW. Codes 0 and 45–63 are invalid.
- Encoding: standard MIPS-I opcodes/functs (SPECIAL op 0, REGIMM op 1, rt = 0/1/16/17 for BLTZ/BGEZ/BLTZAL/BGEZAL).
- Fields not used by an instruction are forced to zero, not taken from the request:
  - rs for SLL/SRL/SRA/LUI.
  - sa for all non-immediate-shift R-type.
  - rt/rd for JR.
  - rt for JALR/BLEZ/BGTZ.
- req_imm[25:16] is ignored except for J/JAL.
- States:
  - IDLE (reset): req_ready=0.
  - RUN: req_ready = (fifo_count < 2).
  - FULL: req_ready=0.
- start from any state moves to RUN. It also discards buffered words, loads the address counter, and clears err_invalid, full and word_cnt.
- Accepted valid op: the encoded word and the current address counter are pushed into a 2-entry FIFO, then the address increments.
  - If the consumed address was 2^ADDR_WIDTH−1: state → FULL, full=1, and the counter wraps to 0 (unused).
- Accepted invalid op: handshake completes, nothing is pushed, no address is consumed, err_invalid=1 until start or reset.
- The FIFO head drives wr_valid/wr_addr/wr_data. Pop on wr_valid && wr_ready; word_cnt increments per pop.
- FIFO push and pop in the same cycle: count unchanged, order preserved.

## Timing
- Reset values:
  - state IDLE
  - req_ready=0, wr_valid=0
  - wr_addr=0, wr_data=0
  - err_invalid=0, full=0, word_cnt=0
  - FIFO empty
- Request accepted at edge N, FIFO empty → wr_valid=1 with that word after edge N (one cycle latency).
- wr_valid, wr_addr and wr_data are held stable while wr_ready=0.
- req_ready is a function of registered state only; no combinational path from wr_ready.
- start is sampled at the edge: it takes effect at the following cycle, and a request handshaking in the same cycle as start is dropped.
- full asserts in the cycle after the last-address request is accepted. Words still in the FIFO drain normally in FULL.
- Reset asserted mid-operation clears everything immediately (asynchronous), including buffered words.

## Test plan
- Reset, start_addr=0x010, req_op=30 (ADDIU) rs=29 rt=29 imm=0xFFF8 → next cycle wr_valid=1, wr_addr=0x010, wr_data=0x27BDFFF8.
- Back-to-back SLL rd=8 rt=9 sa=2 rs=7, JR rs=31 rt=5, JAL imm=0x0100000, BGEZAL rs=4 imm=0x0010, LW rs=29 rt=31 imm=0x0014, with wr_ready=1:
  - wr_data sequence 0x00094080, 0x03E00008, 0x0C100000, 0x04910010, 0x8FBF0014.
  - Consecutive addresses.
  - word_cnt=5.
- wr_ready=0, 3 valid requests → the first two are accepted, req_ready drops; raising wr_ready drains them in order, then the third is accepted; no word lost or duplicated.
- req_op=0, then req_op=50, then ORI → err_invalid=1 after the first; only one write occurs (ORI) at start_addr; err_invalid clears on next start.
- ADDR_WIDTH=4, start_addr=14, 3 requests:
  - Writes to 14 and 15, then full=1 and req_ready=0.
  - The third request is never accepted.
  - start clears full.
- 2 words buffered with wr_ready=0, pulse start with start_addr=0 → FIFO flushed, wr_valid=0, word_cnt=0; the next request writes address 0. Repeat the scenario with rst_n asserted mid-stream → all outputs return to reset values immediately.
